shift_issue_stage: RTL and testbench

- Pipeline stage directly upstream of the 32-bit barrel left shifter in the EX-stage ALU.
- Accepts decoded shift micro-ops from ID/EX over a valid/ready handshake.
- Selects the shift amount from the immediate or the register, and pre-reverses the operand for logical right shifts so the left-only shifter can execute them.
- Registers the shifter inputs, with a 2-entry skid buffer so upstream stalls never break timing.

---
 rtl/shift_issue_stage_pkg.sv | 21 ++
 rtl/shift_issue_stage_if.sv | 36 +++
 rtl/shift_issue_stage_decode.sv | 51 +++++
 rtl/shift_issue_stage.sv | 149 ++++++++++++++
 tb/tb_shift_issue_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_issue_stage_pkg.sv
// rtl/shift_issue_stage_pkg.sv - shared constants and enums for the shift issue stage
package shift_issue_stage_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_SHAMT_W = 5;
   localparam int DEF_TAG_W   = 5;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_PASS = 2'b10,
      OP_ILL  = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } buf_state_e;

endpackage

// File: rtl/shift_issue_stage_if.sv
// rtl/shift_issue_stage_if.sv - micro-op in / shifter-operand out handshake bundle
interface shift_issue_stage_if
   import shift_issue_stage_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SHAMT_W = DEF_SHAMT_W,
   parameter int TAG_W   = DEF_TAG_W
) ();

   logic               in_valid;
   logic               in_ready;
   logic [1:0]         in_op;
   logic [DATA_W-1:0]  in_a;
   logic [DATA_W-1:0]  in_rs;
   logic [SHAMT_W-1:0] in_imm_shamt;
   logic               in_use_imm;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  sh_a;
   logic [SHAMT_W-1:0] sh_shl;
   logic               out_rev;
   logic [TAG_W-1:0]   out_tag;
   logic               out_illegal;

   modport master (
      output in_valid, in_op, in_a, in_rs, in_imm_shamt, in_use_imm, in_tag, out_ready,
      input  in_ready, out_valid, sh_a, sh_shl, out_rev, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_op, in_a, in_rs, in_imm_shamt, in_use_imm, in_tag, out_ready,
      output in_ready, out_valid, sh_a, sh_shl, out_rev, out_tag, out_illegal
   );

endinterface

// File: rtl/shift_issue_stage_decode.sv
// rtl/shift_issue_stage_decode.sv - per-op operand prep for a left-only barrel shifter
module shift_op_decode
   import shift_issue_stage_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic [1:0]         op,
   input  logic [DATA_W-1:0]  a,
   input  logic [SHAMT_W-1:0] amount,
   output logic [DATA_W-1:0]  sh_a,
   output logic [SHAMT_W-1:0] sh_shl,
   output logic               rev,
   output logic               illegal
);

   logic [DATA_W-1:0] a_rev;

   always_comb begin
      a_rev = '0;
      for (int i = 0; i < DATA_W; i++) begin
         a_rev[i] = a[DATA_W-1-i];
      end
   end

   // SRL x by n == reverse(reverse(x) << n); the final reverse happens downstream.
   always_comb begin
      sh_a    = '0;
      sh_shl  = '0;
      rev     = 1'b0;
      illegal = 1'b0;
      case (shift_op_e'(op))
         OP_SLL: begin
            sh_a   = a;
            sh_shl = amount;
         end
         OP_SRL: begin
            sh_a   = a_rev;
            sh_shl = amount;
            rev    = 1'b1;
         end
         OP_PASS: begin
            sh_a = a;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - registered shifter-input stage with 2-entry skid buffer
module shift_issue_stage
   import shift_issue_stage_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SHAMT_W = DEF_SHAMT_W,
   parameter int TAG_W   = DEF_TAG_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   shift_issue_stage_if.slave  bus
);

   buf_state_e state_q, state_d;

   logic               accept;
   logic               drain;
   logic               load_main_in;
   logic               load_main_skid;
   logic               load_skid;

   logic [SHAMT_W-1:0] amount;
   logic [DATA_W-1:0]  dec_a;
   logic [SHAMT_W-1:0] dec_shl;
   logic               dec_rev;
   logic               dec_ill;

   logic [DATA_W-1:0]  main_a,   skid_a;
   logic [SHAMT_W-1:0] main_shl, skid_shl;
   logic               main_rev, skid_rev;
   logic               main_ill, skid_ill;
   logic [TAG_W-1:0]   main_tag, skid_tag;

   logic               unused_rs;

   assign unused_rs = ^bus.in_rs[DATA_W-1:SHAMT_W];
   assign amount    = bus.in_use_imm ? bus.in_imm_shamt : bus.in_rs[SHAMT_W-1:0];

   shift_op_decode #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W)
   ) u_decode (
      .op      (bus.in_op),
      .a       (bus.in_a),
      .amount  (amount),
      .sh_a    (dec_a),
      .sh_shl  (dec_shl),
      .rev     (dec_rev),
      .illegal (dec_ill)
   );

   // Both handshake outputs come straight from the state flop, so neither is combinational from inputs.
   assign bus.in_ready    = (state_q != ST_FULL);
   assign bus.out_valid   = (state_q != ST_EMPTY);
   assign bus.sh_a        = main_a;
   assign bus.sh_shl      = main_shl;
   assign bus.out_rev     = main_rev;
   assign bus.out_tag     = main_tag;
   assign bus.out_illegal = main_ill;

   assign accept = bus.in_valid & bus.in_ready;
   assign drain  = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d      = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  load_main_in = 1'b1;
               end else if (drain) begin
                  state_d = ST_EMPTY;
               end else if (accept) begin
                  state_d   = ST_FULL;
                  load_skid = 1'b1;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  state_d        = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_a   <= '0;
         main_shl <= '0;
         main_rev <= 1'b0;
         main_ill <= 1'b0;
         main_tag <= '0;
      end else if (load_main_in) begin
         main_a   <= dec_a;
         main_shl <= dec_shl;
         main_rev <= dec_rev;
         main_ill <= dec_ill;
         main_tag <= bus.in_tag;
      end else if (load_main_skid) begin
         main_a   <= skid_a;
         main_shl <= skid_shl;
         main_rev <= skid_rev;
         main_ill <= skid_ill;
         main_tag <= skid_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_a   <= '0;
         skid_shl <= '0;
         skid_rev <= 1'b0;
         skid_ill <= 1'b0;
         skid_tag <= '0;
      end else if (load_skid) begin
         skid_a   <= dec_a;
         skid_shl <= dec_shl;
         skid_rev <= dec_rev;
         skid_ill <= dec_ill;
         skid_tag <= bus.in_tag;
      end
   end

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - directed plus random checks against a 2-deep FIFO reference
module tb_shift_issue_stage;
   import shift_issue_stage_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   shift_issue_stage_if bus ();

   shift_issue_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [4:0]  shl;
      logic        rev;
      logic        ill;
      logic [4:0]  tag;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [31:0] reverse32(input logic [31:0] x);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction

   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] rs,
                                  input logic [4:0] imm, input logic use_imm, input logic [4:0] tag);
      exp_t e;
      int   amt;
      amt   = use_imm ? int'(imm) : int'(rs % 32);
      e.a   = 32'h0;
      e.shl = 5'd0;
      e.rev = 1'b0;
      e.ill = 1'b0;
      e.tag = tag;
      if (op == 2'b00) begin
         e.a   = a;
         e.shl = 5'(amt);
      end else if (op == 2'b01) begin
         e.a   = reverse32(a);
         e.shl = 5'(amt);
         e.rev = 1'b1;
      end else if (op == 2'b10) begin
         e.a = a;
      end else begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
      chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, q.size() < 2});
      if (q.size() > 0) begin
         chk("sh_a",        bus.sh_a,                 q[0].a);
         chk("sh_shl",      {27'd0, bus.sh_shl},      {27'd0, q[0].shl});
         chk("out_rev",     {31'd0, bus.out_rev},     {31'd0, q[0].rev});
         chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, q[0].ill});
         chk("out_tag",     {27'd0, bus.out_tag},     {27'd0, q[0].tag});
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] rs,
                        input logic [4:0] imm, input logic use_imm, input logic [4:0] tag);
      bus.in_valid     = v;
      bus.in_op        = op;
      bus.in_a         = a;
      bus.in_rs        = rs;
      bus.in_imm_shamt = imm;
      bus.in_use_imm   = use_imm;
      bus.in_tag       = tag;
   endtask

   // One clock: model decides acceptance from its own occupancy, never from the DUT.
   task automatic cycle();
      bit   acc;
      bit   drn;
      exp_t e;
      acc = bus.in_valid && (q.size() < 2);
      drn = bus.out_ready && (q.size() > 0);
      e   = model(bus.in_op, bus.in_a, bus.in_rs, bus.in_imm_shamt, bus.in_use_imm, bus.in_tag);
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      #1;
      check_outputs();
   endtask

   initial begin
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0);
      bus.out_ready = 1'b0;

      #12;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst_sh_a",      bus.sh_a,               32'd0);
      chk("rst_sh_shl",    {27'd0, bus.sh_shl},    32'd0);
      chk("rst_rev",       {31'd0, bus.out_rev},   32'd0);
      chk("rst_ill",       {31'd0, bus.out_illegal}, 32'd0);
      chk("rst_tag",       {27'd0, bus.out_tag},   32'd0);
      #10;
      rst_n = 1'b1;

      // SLL by immediate
      bus.out_ready = 1'b1;
      drive(1'b1, OP_SLL, 32'h0000_0001, 32'h0, 5'd4, 1'b1, 5'd1);
      cycle();
      chk("sll_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("sll_sh_a",  bus.sh_a, 32'h0000_0001);
      chk("sll_shl",   {27'd0, bus.sh_shl}, 32'd4);
      chk("sll_rev",   {31'd0, bus.out_rev}, 32'd0);
      bus.in_valid = 1'b0;
      cycle();

      // SRL by register, upper rs bits ignored
      drive(1'b1, OP_SRL, 32'h8000_0000, 32'hFFFF_FFE3, 5'd9, 1'b0, 5'd2);
      cycle();
      chk("srl_sh_a", bus.sh_a, 32'h0000_0001);
      chk("srl_shl",  {27'd0, bus.sh_shl}, 32'd3);
      chk("srl_rev",  {31'd0, bus.out_rev}, 32'd1);
      bus.in_valid = 1'b0;
      cycle();

      // Backpressure: three back-to-back ops with the sink stalled
      bus.out_ready = 1'b0;
      drive(1'b1, OP_SLL, 32'h1111_1111, 32'h0, 5'd1, 1'b1, 5'd10);
      cycle();
      drive(1'b1, OP_SRL, 32'h2222_2222, 32'h0, 5'd2, 1'b1, 5'd11);
      cycle();
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      drive(1'b1, OP_PASS, 32'h3333_3333, 32'h0, 5'd3, 1'b1, 5'd12);
      cycle();
      chk("bp_head_tag", {27'd0, bus.out_tag}, 32'd10);
      bus.out_ready = 1'b1;
      cycle();
      chk("bp_second_tag", {27'd0, bus.out_tag}, 32'd11);
      cycle();
      chk("bp_third_tag", {27'd0, bus.out_tag}, 32'd12);
      bus.in_valid = 1'b0;
      cycle();
      chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

      // PASS ignores amount; illegal is still delivered
      drive(1'b1, OP_PASS, 32'hCAFE_F00D, 32'h0, 5'd17, 1'b1, 5'd3);
      cycle();
      chk("pass_shl", {27'd0, bus.sh_shl}, 32'd0);
      drive(1'b1, OP_ILL, 32'hDEAD_BEEF, 32'h7, 5'd7, 1'b1, 5'd4);
      cycle();
      chk("ill_flag",  {31'd0, bus.out_illegal}, 32'd1);
      chk("ill_sh_a",  bus.sh_a, 32'd0);
      chk("ill_valid", {31'd0, bus.out_valid}, 32'd1);
      bus.in_valid = 1'b0;
      cycle();

      // Flush while FULL with a concurrent valid op
      bus.out_ready = 1'b0;
      drive(1'b1, OP_SLL, 32'hA, 32'h0, 5'd1, 1'b1, 5'd20);
      cycle();
      drive(1'b1, OP_SLL, 32'hB, 32'h0, 5'd2, 1'b1, 5'd21);
      cycle();
      drive(1'b1, OP_SLL, 32'hC, 32'h0, 5'd3, 1'b1, 5'd22);
      cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      cycle();
      chk("flush_no_leak", {31'd0, bus.out_valid}, 32'd0);

      // Asynchronous reset mid-cycle while FULL
      bus.out_ready = 1'b0;
      drive(1'b1, OP_SRL, 32'hF0F0_0000, 32'h0, 5'd5, 1'b1, 5'd30);
      cycle();
      drive(1'b1, OP_SLL, 32'h0F0F_0000, 32'h0, 5'd6, 1'b1, 5'd31);
      cycle();
      chk("pre_arst_full", {31'd0, bus.in_ready}, 32'd0);
      #3;
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("arst_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("arst_sh_a",  bus.sh_a, 32'd0);
      chk("arst_rev",   {31'd0, bus.out_rev}, 32'd0);
      chk("arst_tag",   {27'd0, bus.out_tag}, 32'd0);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b1;

      // Random traffic against the FIFO reference
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         bus.out_ready = 1'($urandom_range(0, 2) != 0);
         flush = 1'($urandom_range(0, 24) == 0);
         cycle();
      end
      flush = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
